// File: rtl/mux_pkg.sv
// mux_pkg: shared mode encodings and round-robin helper for rr_mux_n
package mux_pkg;
  localparam logic MODE_RR = 1'b0;
  localparam logic MODE_FIX = 1'b1;
  function automatic int rr_start(int ptr, int nch);
    return (ptr + 1) % nch;
  endfunction
endpackage

// File: rtl/rr_arb_n.sv
// rr_arb_n: combinational round-robin arbiter, first request after ptr wins
module rr_arb_n
  import mux_pkg::*;
#(
  parameter int NCH = 8,
  localparam int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  grant
);
  logic [SELW-1:0] st;
  logic [2*NCH-1:0] dreq, dg;
  logic [NCH-1:0] rot, rg;
  // rotate so the search start sits at bit 0, isolate lowest set bit, rotate back
  always_comb begin
    st = SELW'(rr_start(int'(ptr), NCH));
    dreq = {req, req} >> st;
    rot = dreq[NCH-1:0];
    rg = rot & (~rot + NCH'(1));
    dg = {{NCH{1'b0}}, rg} << st;
    grant = dg[NCH-1:0] | dg[2*NCH-1:NCH];
  end
endmodule

// File: rtl/rr_mux_n.sv
// rr_mux_n: N-channel registered mux with round-robin or fixed selection and valid/ready handshake
module rr_mux_n
  import mux_pkg::*;
#(
  parameter int NCH = 8,
  parameter int W = 8,
  localparam int SELW = $clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    in_valid,
  input  logic [NCH*W-1:0]  in_data,
  output logic [NCH-1:0]    in_ready,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_ch,
  input  logic              out_ready
);
  localparam int NSEL = 1 << SELW;
  logic [SELW-1:0] ptr, gidx;
  logic [NCH-1:0] rr_g, grant;
  logic [NSEL-1:0] fix_hit;
  logic [W-1:0] gdata;
  logic load_en;
  rr_arb_n #(.NCH(NCH)) u_arb (.req(in_valid), .ptr(ptr), .grant(rr_g));
  // selects beyond NCH land on zero-extended valid bits, so they never grant
  always_comb begin
    fix_hit = NSEL'(in_valid) & (NSEL'(1) << sel);
    grant = mode == MODE_FIX ? fix_hit[NCH-1:0] : rr_g;
    load_en = ~out_valid | out_ready;
    in_ready = (load_en & ~rst) ? grant : '0;
    gidx = '0;
    gdata = '0;
    for (int i = 0; i < NCH; i++)
      if (grant[i]) begin
        gidx = SELW'(i);
        gdata = in_data[i*W +: W];
      end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
      ptr <= SELW'(NCH - 1);
    end else if (load_en) begin
      out_valid <= |grant;
      if (|grant) begin
        out_data <= gdata;
        out_ch <= gidx;
        ptr <= gidx;
      end
    end
endmodule

// File: tb/tb_rr_mux_n.sv
// tb_rr_mux_n: directed tests for rr_mux_n with NCH=8, W=8
module tb_rr_mux_n;
  logic clk = 0, rst = 1, mode = 0, out_ready = 1, out_valid;
  logic [7:0] in_valid = 0, in_ready, out_data;
  logic [63:0] in_data;
  logic [2:0] sel = 0, out_ch;
  int total = 0, bad = 0;

  rr_mux_n #(.NCH(8), .W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", out_data); end
    total++; if (out_ch !== 3'd0) begin bad++; $display("FAIL rst_ch got=%0d exp=0", out_ch); end
    in_valid = 8'hFF;
    #1;
    total++; if (in_ready !== 8'h00) begin bad++; $display("FAIL rst_in_ready got=%h exp=00", in_ready); end
    rst = 0;
    #1;
    total++; if (in_ready !== 8'h01) begin bad++; $display("FAIL first_ready got=%h exp=01", in_ready); end
    tick();
    total++; if (out_valid !== 1'b1 || out_ch !== 3'd0 || out_data !== 8'h10) begin bad++; $display("FAIL first_load got=%b/%0d/%h exp=1/0/10", out_valid, out_ch, out_data); end
    out_ready = 0;
    #1 rst = 1;
    #1;
    total++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 3'd0) begin bad++; $display("FAIL async_rst got=%b/%0d/%h exp=0/0/00", out_valid, out_ch, out_data); end
    total++; if (in_ready !== 8'h00) begin bad++; $display("FAIL rst_held_ready got=%h exp=00", in_ready); end
    in_valid = 8'h00;
    out_ready = 1;
    tick();
    rst = 0;
  endtask

  task automatic test_rr_fair();
    in_valid = 8'hFF;
    for (int k = 0; k < 16; k++) begin
      tick();
      total++; if (out_valid !== 1'b1 || out_ch !== 3'(k % 8) || out_data !== 8'(8'h10 + k % 8)) begin bad++; $display("FAIL fair[%0d] got=%b/%0d/%h exp=1/%0d/%h", k, out_valid, out_ch, out_data, k % 8, 8'h10 + k % 8); end
    end
    in_valid = 8'h00;
    tick();
  endtask

  task automatic test_sparse();
    logic [2:0] exp_ch[6] = '{3'd1, 3'd4, 3'd7, 3'd1, 3'd4, 3'd7};
    in_valid = 8'b1001_0010;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++; if (out_valid !== 1'b1 || out_ch !== exp_ch[k]) begin bad++; $display("FAIL sparse[%0d] got=%b/%0d exp=1/%0d", k, out_valid, out_ch, exp_ch[k]); end
    end
    in_valid = 8'h00;
    tick();
  endtask

  task automatic test_back_pressure();
    in_data[3*8 +: 8] = 8'hA5;
    in_valid = 8'b0000_1000;
    tick();
    total++; if (out_ch !== 3'd3 || out_data !== 8'hA5) begin bad++; $display("FAIL bp_load got=%0d/%h exp=3/a5", out_ch, out_data); end
    in_valid = 8'hFF;
    out_ready = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (in_ready !== 8'h00) begin bad++; $display("FAIL bp_ready[%0d] got=%h exp=00", k, in_ready); end
      tick();
      total++; if (out_valid !== 1'b1 || out_ch !== 3'd3 || out_data !== 8'hA5) begin bad++; $display("FAIL bp_hold[%0d] got=%b/%0d/%h exp=1/3/a5", k, out_valid, out_ch, out_data); end
    end
    out_ready = 1;
    #1;
    total++; if (in_ready !== 8'h10) begin bad++; $display("FAIL bp_release_ready got=%h exp=10", in_ready); end
    tick();
    total++; if (out_ch !== 3'd4 || out_data !== 8'h14) begin bad++; $display("FAIL bp_next got=%0d/%h exp=4/14", out_ch, out_data); end
    in_data[3*8 +: 8] = 8'h13;
    in_valid = 8'h00;
    tick();
  endtask

  task automatic test_fixed();
    mode = 1;
    sel = 3'd5;
    in_valid = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (in_ready !== 8'h20) begin bad++; $display("FAIL fix_ready[%0d] got=%h exp=20", k, in_ready); end
      tick();
      total++; if (out_valid !== 1'b1 || out_ch !== 3'd5 || out_data !== 8'h15) begin bad++; $display("FAIL fix_out[%0d] got=%b/%0d/%h exp=1/5/15", k, out_valid, out_ch, out_data); end
    end
    in_valid = 8'hDF;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fix_novalid got=%b exp=0", out_valid); end
    mode = 0;
    in_valid = 8'hFF;
    #1;
    total++; if (in_ready !== 8'h40) begin bad++; $display("FAIL rr_resume_ready got=%h exp=40", in_ready); end
    tick();
    total++; if (out_ch !== 3'd6 || out_data !== 8'h16) begin bad++; $display("FAIL rr_resume got=%0d/%h exp=6/16", out_ch, out_data); end
  endtask

  task automatic test_empty();
    in_valid = 8'h01;
    tick();
    total++; if (out_valid !== 1'b1 || out_ch !== 3'd0 || out_data !== 8'h10) begin bad++; $display("FAIL empty_load got=%b/%0d/%h exp=1/0/10", out_valid, out_ch, out_data); end
    in_valid = 8'h00;
    tick();
    total++; if (out_valid !== 1'b0 || out_data !== 8'h10 || out_ch !== 3'd0) begin bad++; $display("FAIL empty_hold got=%b/%0d/%h exp=0/0/10", out_valid, out_ch, out_data); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'(8'h10 + i);
    test_reset();
    test_rr_fair();
    test_sparse();
    test_back_pressure();
    test_fixed();
    test_empty();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
